// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the boot-time sysid verifier.
package sysid_checker_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ID_REQ,
        ID_WAIT,
        TS_REQ,
        TS_WAIT,
        DONE
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_checker.sv
// Avalon-MM master that reads the sysid ID and timestamp words and compares
// them against build-time expected values.
module sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1480436679,
    parameter int unsigned TIMEOUT_CYCLES     = 256,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam int unsigned     CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state, next_state;
    logic [CW-1:0] cnt, cnt_d;
    logic          auto_pend;
    logic          in_xfer, complete, expire;

    logic          read_d, addr_d, busy_d, done_d, pass_d;
    logic          id_ok_d, ts_ok_d, timeout_d;
    logic [31:0]   id_value_d, ts_value_d;

    // Auto-start request lives for exactly the first cycle after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            auto_pend <= AUTO_START;
        end else begin
            state     <= next_state;
            auto_pend <= 1'b0;
        end
    end

    always_comb begin
        in_xfer  = state inside {ID_REQ, ID_WAIT, TS_REQ, TS_WAIT};
        complete = 1'b0;
        case (state)
            ID_REQ, TS_REQ:   complete = !avm_waitrequest;
            ID_WAIT, TS_WAIT: complete = avm_readdatavalid;
            default:          complete = 1'b0;
        endcase
        // Completion on the last allowed cycle takes priority over expiry.
        expire = in_xfer && (cnt == CNT_LAST) && !complete;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start || auto_pend) next_state = ID_REQ;
            ID_REQ:  if (complete) next_state = ID_WAIT; else if (expire) next_state = DONE;
            ID_WAIT: if (complete) next_state = TS_REQ;  else if (expire) next_state = DONE;
            TS_REQ:  if (complete) next_state = TS_WAIT; else if (expire) next_state = DONE;
            TS_WAIT: if (complete || expire) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        read_d     = next_state inside {ID_REQ, TS_REQ};
        addr_d     = (next_state inside {TS_REQ, TS_WAIT}) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
        busy_d     = next_state != IDLE;
        done_d     = next_state == DONE;
        pass_d     = pass;
        id_ok_d    = id_ok;
        ts_ok_d    = ts_ok;
        timeout_d  = timeout;
        id_value_d = id_value;
        ts_value_d = ts_value;

        if (state == IDLE && next_state == ID_REQ) begin
            pass_d     = 1'b0;
            id_ok_d    = 1'b0;
            ts_ok_d    = 1'b0;
            timeout_d  = 1'b0;
            id_value_d = '0;
            ts_value_d = '0;
        end
        if (state == ID_WAIT && avm_readdatavalid) begin
            id_value_d = avm_readdata;
            id_ok_d    = avm_readdata == EXPECTED_ID;
        end
        if (state == TS_WAIT && avm_readdatavalid) begin
            ts_value_d = avm_readdata;
            ts_ok_d    = avm_readdata == EXPECTED_TIMESTAMP;
        end
        if (expire) timeout_d = 1'b1;
        if (next_state == DONE) pass_d = id_ok_d & ts_ok_d & ~timeout_d;

        cnt_d = cnt;
        if ((next_state inside {ID_REQ, TS_REQ}) && next_state != state) cnt_d = '0;
        else if (in_xfer) cnt_d = cnt + CW'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            avm_read    <= 1'b0;
            avm_address <= SYSID_ADDR_ID;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
            cnt         <= '0;
        end else begin
            avm_read    <= read_d;
            avm_address <= addr_d;
            busy        <= busy_d;
            done        <= done_d;
            pass        <= pass_d;
            id_ok       <= id_ok_d;
            ts_ok       <= ts_ok_d;
            timeout     <= timeout_d;
            id_value    <= id_value_d;
            ts_value    <= ts_value_d;
            cnt         <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: main instance with a scripted sysid slave,
// plus a short-timeout instance whose slave never responds.
module tb_sysid_checker;

    localparam logic [31:0] TS_GOOD = 32'd1480436679;

    logic        clock;
    logic        reset_n;
    int          n_pass;
    int          n_total;

    // main instance
    logic        start_m, m_addr, m_read, m_wait, m_rdv;
    logic [31:0] m_data;
    logic        m_busy, m_done, m_pass, m_id_ok, m_ts_ok, m_timeout;
    logic [31:0] m_id_value, m_ts_value;

    // timeout instance
    logic        start_t, t_addr, t_read, t_wait, t_rdv;
    logic [31:0] t_data;
    logic        t_busy, t_done, t_pass, t_id_ok, t_ts_ok, t_timeout;
    logic [31:0] t_id_value, t_ts_value;

    // slave model controls
    logic [31:0] id_data, ts_data;
    int          wr_id, wr_ts, wr_cnt;
    logic        drop_rsp, inject, pend, pend_addr;

    sysid_checker #(
        .EXPECTED_ID(32'd0), .EXPECTED_TIMESTAMP(TS_GOOD),
        .TIMEOUT_CYCLES(256), .AUTO_START(1'b1)
    ) u_main (
        .clock(clock), .reset_n(reset_n), .start(start_m),
        .avm_address(m_addr), .avm_read(m_read), .avm_waitrequest(m_wait),
        .avm_readdata(m_data), .avm_readdatavalid(m_rdv),
        .busy(m_busy), .done(m_done), .pass(m_pass), .id_ok(m_id_ok),
        .ts_ok(m_ts_ok), .timeout(m_timeout), .id_value(m_id_value), .ts_value(m_ts_value)
    );

    sysid_checker #(
        .EXPECTED_ID(32'd0), .EXPECTED_TIMESTAMP(TS_GOOD),
        .TIMEOUT_CYCLES(4), .AUTO_START(1'b0)
    ) u_to (
        .clock(clock), .reset_n(reset_n), .start(start_t),
        .avm_address(t_addr), .avm_read(t_read), .avm_waitrequest(t_wait),
        .avm_readdata(t_data), .avm_readdatavalid(t_rdv),
        .busy(t_busy), .done(t_done), .pass(t_pass), .id_ok(t_id_ok),
        .ts_ok(t_ts_ok), .timeout(t_timeout), .id_value(t_id_value), .ts_value(t_ts_value)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Slave for u_main: drives inputs shortly after each falling edge so that
    // stimulus written by the tests at that edge is already visible.
    always begin
        @(negedge clock);
        #1;
        if (!reset_n) begin
            pend = 1'b0; wr_cnt = 0; m_wait = 1'b0; m_rdv = 1'b0;
        end else begin
            m_rdv = 1'b0;
            if (pend && !drop_rsp) begin
                m_rdv  = 1'b1;
                m_data = pend_addr ? ts_data : id_data;
            end
            pend = 1'b0;
            if (inject) begin
                m_rdv  = 1'b1;
                m_data = 32'hBAD0_BAD0;
            end
            m_wait = 1'b0;
            if (m_read) begin
                if (wr_cnt < (m_addr ? wr_ts : wr_id)) begin
                    m_wait = 1'b1;
                    wr_cnt++;
                end else begin
                    wr_cnt = 0; pend = 1'b1; pend_addr = m_addr;
                end
            end
        end
    end

    task automatic wait_done_m(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (i == 1) start_m = 1'b0;
            if (m_done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        n_total++; if (m_read !== 1'b0) $display("FAIL reset_read got %b exp 0", m_read); else n_pass++;
        n_total++; if (m_busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", m_busy); else n_pass++;
        n_total++; if (m_done !== 1'b0) $display("FAIL reset_done got %b exp 0", m_done); else n_pass++;
        n_total++; if ({m_pass, m_id_ok, m_ts_ok, m_timeout} !== 4'b0)
            $display("FAIL reset_flags got %b exp 0000", {m_pass, m_id_ok, m_ts_ok, m_timeout}); else n_pass++;
        n_total++; if (m_id_value !== 32'd0 || m_ts_value !== 32'd0)
            $display("FAIL reset_values got %h/%h exp 0/0", m_id_value, m_ts_value); else n_pass++;
        n_total++; if (m_addr !== 1'b0) $display("FAIL reset_addr got %b exp 0", m_addr); else n_pass++;
    endtask

    task automatic test_auto_start();
        int c;
        reset_n = 1'b1;
        wait_done_m(c);
        n_total++; if (c !== 5) $display("FAIL auto_done_cycle got %0d exp 5", c); else n_pass++;
        n_total++; if (m_pass !== 1'b1) $display("FAIL auto_pass got %b exp 1", m_pass); else n_pass++;
    endtask

    task automatic test_basic();
        int c;
        int busy_cyc;
        c = -1;
        busy_cyc = -1;
        @(negedge clock);
        start_m = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (i == 1) start_m = 1'b0;
            if (busy_cyc < 0 && m_busy && m_read) busy_cyc = i;
            if (m_done) begin
                c = i;
                break;
            end
        end
        n_total++; if (busy_cyc !== 1) $display("FAIL basic_busy_cycle got %0d exp 1", busy_cyc); else n_pass++;
        n_total++; if (c !== 5) $display("FAIL basic_done_cycle got %0d exp 5", c); else n_pass++;
        n_total++; if (m_pass !== 1'b1) $display("FAIL basic_pass got %b exp 1", m_pass); else n_pass++;
        n_total++; if (m_id_ok !== 1'b1 || m_ts_ok !== 1'b1)
            $display("FAIL basic_ok got %b%b exp 11", m_id_ok, m_ts_ok); else n_pass++;
        n_total++; if (m_timeout !== 1'b0) $display("FAIL basic_timeout got %b exp 0", m_timeout); else n_pass++;
        n_total++; if (m_ts_value !== TS_GOOD) $display("FAIL basic_ts_value got %h exp %h", m_ts_value, TS_GOOD); else n_pass++;
        @(negedge clock);
        n_total++; if (m_done !== 1'b0 || m_busy !== 1'b0)
            $display("FAIL basic_after_done got done=%b busy=%b exp 0/0", m_done, m_busy); else n_pass++;
        n_total++; if (m_pass !== 1'b1) $display("FAIL basic_pass_hold got %b exp 1", m_pass); else n_pass++;
    endtask

    task automatic test_ts_mismatch();
        int c;
        ts_data = 32'hDEAD_BEEF;
        @(negedge clock);
        start_m = 1'b1;
        wait_done_m(c);
        n_total++; if (c !== 5) $display("FAIL mis_done_cycle got %0d exp 5", c); else n_pass++;
        n_total++; if (m_id_ok !== 1'b1) $display("FAIL mis_id_ok got %b exp 1", m_id_ok); else n_pass++;
        n_total++; if (m_ts_ok !== 1'b0) $display("FAIL mis_ts_ok got %b exp 0", m_ts_ok); else n_pass++;
        n_total++; if (m_pass !== 1'b0) $display("FAIL mis_pass got %b exp 0", m_pass); else n_pass++;
        n_total++; if (m_ts_value !== 32'hDEAD_BEEF) $display("FAIL mis_ts_value got %h exp deadbeef", m_ts_value); else n_pass++;
        ts_data = TS_GOOD;
    endtask

    task automatic test_waitrequest();
        int c;
        int id_rd;
        logic unstable;
        c = -1;
        id_rd = 0;
        unstable = 1'b0;
        wr_id = 3;
        @(negedge clock);
        start_m = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (i == 1) start_m = 1'b0;
            if (i <= 4 && (m_read !== 1'b1 || m_addr !== 1'b0)) unstable = 1'b1;
            if (m_read && !m_addr) id_rd++;
            if (m_done) begin
                c = i;
                break;
            end
        end
        wr_id = 0;
        n_total++; if (unstable !== 1'b0) $display("FAIL wr_stable got unstable=%b exp 0", unstable); else n_pass++;
        n_total++; if (id_rd !== 4) $display("FAIL wr_id_read_cycles got %0d exp 4", id_rd); else n_pass++;
        n_total++; if (c !== 8) $display("FAIL wr_done_cycle got %0d exp 8", c); else n_pass++;
        n_total++; if (m_pass !== 1'b1) $display("FAIL wr_pass got %b exp 1", m_pass); else n_pass++;
    endtask

    task automatic test_timeout();
        int c;
        logic ts_issued;
        c = -1;
        ts_issued = 1'b0;
        @(negedge clock);
        start_t = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (i == 1) start_t = 1'b0;
            if (t_read && t_addr) ts_issued = 1'b1;
            if (t_done) begin
                c = i;
                break;
            end
        end
        n_total++; if (c !== 5) $display("FAIL to_done_cycle got %0d exp 5", c); else n_pass++;
        n_total++; if (t_timeout !== 1'b1) $display("FAIL to_timeout got %b exp 1", t_timeout); else n_pass++;
        n_total++; if (t_pass !== 1'b0) $display("FAIL to_pass got %b exp 0", t_pass); else n_pass++;
        n_total++; if (t_id_ok !== 1'b0 || t_ts_ok !== 1'b0)
            $display("FAIL to_ok got %b%b exp 00", t_id_ok, t_ts_ok); else n_pass++;
        n_total++; if (ts_issued !== 1'b0) $display("FAIL to_ts_issued got %b exp 0", ts_issued); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int c;
        c = -1;
        drop_rsp = 1'b1;
        @(negedge clock);
        start_m = 1'b1;
        @(negedge clock);
        start_m = 1'b0;
        @(negedge clock);
        n_total++; if (m_busy !== 1'b1 || m_read !== 1'b0)
            $display("FAIL rmid_in_wait got busy=%b read=%b exp 1/0", m_busy, m_read); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_total++; if (m_busy !== 1'b0 || m_done !== 1'b0)
            $display("FAIL rmid_async got busy=%b done=%b exp 0/0", m_busy, m_done); else n_pass++;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        drop_rsp = 1'b0;
        inject = 1'b1;
        n_total++; if ({m_pass, m_id_ok, m_ts_ok, m_timeout} !== 4'b0 || m_id_value !== 32'd0)
            $display("FAIL rmid_reset_vals got %b %h exp 0000 0", {m_pass, m_id_ok, m_ts_ok, m_timeout}, m_id_value); else n_pass++;
        // stale responses during cycles 0 and 1 must not be captured
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (i == 2) inject = 1'b0;
            if (m_done) begin
                c = i;
                break;
            end
        end
        inject = 1'b0;
        n_total++; if (c !== 5) $display("FAIL rmid_done_cycle got %0d exp 5", c); else n_pass++;
        n_total++; if (m_pass !== 1'b1) $display("FAIL rmid_pass got %b exp 1", m_pass); else n_pass++;
        n_total++; if (m_id_value !== 32'd0) $display("FAIL rmid_id_value got %h exp 0", m_id_value); else n_pass++;
    endtask

    task automatic test_busy_start();
        int n_done;
        int first;
        n_done = 0;
        first = -1;
        @(negedge clock);
        start_m = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clock);
            start_m = (i == 2 || i == 5);
            if (m_done) begin
                n_done++;
                if (first < 0) first = i;
            end
        end
        start_m = 1'b0;
        n_total++; if (n_done !== 1) $display("FAIL busy_done_count got %0d exp 1", n_done); else n_pass++;
        n_total++; if (first !== 5) $display("FAIL busy_done_cycle got %0d exp 5", first); else n_pass++;
        n_total++; if (m_busy !== 1'b0) $display("FAIL busy_idle_after got %b exp 0", m_busy); else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        reset_n = 1'b0;
        start_m = 1'b0;
        start_t = 1'b0;
        id_data = 32'd0;
        ts_data = TS_GOOD;
        wr_id = 0;
        wr_ts = 0;
        wr_cnt = 0;
        drop_rsp = 1'b0;
        inject = 1'b0;
        pend = 1'b0;
        pend_addr = 1'b0;
        m_wait = 1'b0;
        m_rdv = 1'b0;
        m_data = 32'd0;
        t_wait = 1'b0;
        t_rdv = 1'b0;
        t_data = 32'd0;

        test_reset();
        test_auto_start();
        test_basic();
        test_ts_mismatch();
        test_waitrequest();
        test_timeout();
        test_reset_mid();
        test_busy_start();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
